clock_adjust_ctrl: RTL and testbench

Time-keeping and time-setting controller for the alarm clock, directly downstream of the pushbutton detector stage. It consumes single-cycle button pulses (one detector instance per button) and a 1 Hz enable tick. It maintains clock time (hh:mm:ss) and alarm time (hh:mm), runs the RUN/ADJUST mode FSM, and drives alarm_ring to the display/buzzer stage.

---
 rtl/clock_adjust_ctrl_pkg.sv | 31 +++
 rtl/clock_adjust_ctrl_wrap.sv | 44 ++++
 rtl/clock_adjust_ctrl.sv | 156 +++++++++++++++
 tb/tb_clock_adjust_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_adjust_ctrl_pkg.sv
// ============================================================================
//  Module      : clock_adjust_ctrl_pkg
//  Description : Shared types and constants for the alarm-clock time/adjust
//                controller (FSM encoding, field codes, field widths).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package clock_adjust_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        ADJUST = 1'b1
    } state_t;

    localparam logic [1:0] FLD_CMIN = 2'd0;
    localparam logic [1:0] FLD_CHR  = 2'd1;
    localparam logic [1:0] FLD_AMIN = 2'd2;
    localparam logic [1:0] FLD_AHR  = 2'd3;

    localparam int HR_W = 5;
    localparam int MS_W = 6;

    // Value that follows v in a 0..max wrapping sequence.
    function automatic int unsigned next_wrap(input int unsigned v, input int unsigned max);
        return (v >= max) ? 0 : v + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_adjust_ctrl_wrap.sv
// ============================================================================
//  Module      : wrap_counter
//  Description : Up/down counter wrapping over 0..MAX with clear and an
//                increment-wrap carry.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wrap_counter #(
    parameter int WIDTH   = 6,
    parameter int MAX     = 59,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] C_RST = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    // Simultaneous inc and dec cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= C_RST;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !dec) begin
            value <= (value == C_MAX) ? '0 : value + C_ONE;
        end else if (dec && !inc) begin
            value <= (value == '0) ? C_MAX : value - C_ONE;
        end
    end

    assign carry = inc && !dec && !clr && (value == C_MAX);

endmodule

`default_nettype wire

// File: rtl/clock_adjust_ctrl.sv
// ============================================================================
//  Module      : clock_adjust_ctrl
//  Description : Alarm-clock timekeeping, RUN/ADJUST setting FSM and alarm
//                ring control. Optional macro CLK_ADJ_BLINK_EN enables blink.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module clock_adjust_ctrl
    import clock_adjust_ctrl_pkg::*;
#(
    parameter int HOUR_MAX    = 23,
    parameter int MIN_MAX     = 59,
    parameter int ALARM_RST_H = 7,
    parameter int ALARM_RST_M = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_1hz,
    input  logic            btn_mode,
    input  logic            btn_left,
    input  logic            btn_right,
    input  logic            btn_up,
    input  logic            btn_down,
    input  logic            alarm_en,
    output logic [HR_W-1:0] hours,
    output logic [MS_W-1:0] minutes,
    output logic [MS_W-1:0] seconds,
    output logic [HR_W-1:0] alarm_hours,
    output logic [MS_W-1:0] alarm_minutes,
    output logic            adj_mode,
    output logic [1:0]      sel_field,
    output logic            blink,
    output logic            alarm_ring
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_sel;
    logic            r_ring;
    logic            w_run, w_adj, w_edit, w_tick, w_exit, w_any_btn;
    logic            w_sec_c, w_min_c, w_hr_c, w_amin_c, w_ahr_c;
    logic            w_unused_carry;
    logic            w_ring_set;
    logic [MS_W-1:0] w_nxt_min;
    logic [HR_W-1:0] w_nxt_hr;

    assign w_run     = (r_state == RUN);
    assign w_adj     = (r_state == ADJUST);
    assign w_edit    = w_adj && !btn_mode;
    assign w_tick    = w_run && tick_1hz && !btn_mode;
    assign w_exit    = w_adj && btn_mode;
    assign w_any_btn = btn_mode | btn_left | btn_right | btn_up | btn_down;

    always_comb begin
        w_state_nxt = r_state;
        if (btn_mode) begin
            w_state_nxt = (r_state == RUN) ? ADJUST : RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel <= FLD_CMIN;
        end else if (w_edit && btn_right && !btn_left) begin
            r_sel <= r_sel + 2'd1;
        end else if (w_edit && btn_left && !btn_right) begin
            r_sel <= r_sel - 2'd1;
        end
    end

    wrap_counter #(.WIDTH(MS_W), .MAX(MIN_MAX), .RST_VAL(0)) u_sec (
        .clk(clk), .rst(rst), .inc(w_tick), .dec(1'b0), .clr(w_exit),
        .value(seconds), .carry(w_sec_c)
    );

    wrap_counter #(.WIDTH(MS_W), .MAX(MIN_MAX), .RST_VAL(0)) u_cmin (
        .clk(clk), .rst(rst),
        .inc(w_sec_c || (w_edit && btn_up && r_sel == FLD_CMIN)),
        .dec(w_edit && btn_down && r_sel == FLD_CMIN), .clr(1'b0),
        .value(minutes), .carry(w_min_c)
    );

    // Minute carry only counts during timekeeping; manual edits never ripple.
    wrap_counter #(.WIDTH(HR_W), .MAX(HOUR_MAX), .RST_VAL(0)) u_chr (
        .clk(clk), .rst(rst),
        .inc((w_run && w_min_c) || (w_edit && btn_up && r_sel == FLD_CHR)),
        .dec(w_edit && btn_down && r_sel == FLD_CHR), .clr(1'b0),
        .value(hours), .carry(w_hr_c)
    );

    wrap_counter #(.WIDTH(MS_W), .MAX(MIN_MAX), .RST_VAL(ALARM_RST_M)) u_amin (
        .clk(clk), .rst(rst),
        .inc(w_edit && btn_up && r_sel == FLD_AMIN),
        .dec(w_edit && btn_down && r_sel == FLD_AMIN), .clr(1'b0),
        .value(alarm_minutes), .carry(w_amin_c)
    );

    wrap_counter #(.WIDTH(HR_W), .MAX(HOUR_MAX), .RST_VAL(ALARM_RST_H)) u_ahr (
        .clk(clk), .rst(rst),
        .inc(w_edit && btn_up && r_sel == FLD_AHR),
        .dec(w_edit && btn_down && r_sel == FLD_AHR), .clr(1'b0),
        .value(alarm_hours), .carry(w_ahr_c)
    );

    assign w_unused_carry = w_hr_c ^ w_amin_c ^ w_ahr_c;

    // hh:mm as it will read after this tick's seconds rollover.
    assign w_nxt_min  = MS_W'(next_wrap(32'(minutes), MIN_MAX));
    assign w_nxt_hr   = (minutes == MS_W'(MIN_MAX)) ? HR_W'(next_wrap(32'(hours), HOUR_MAX)) : hours;
    assign w_ring_set = w_sec_c && alarm_en &&
                        (w_nxt_hr == alarm_hours) && (w_nxt_min == alarm_minutes);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ring <= 1'b0;
        end else if (w_any_btn || !alarm_en) begin
            r_ring <= 1'b0;
        end else if (w_ring_set) begin
            r_ring <= 1'b1;
        end
    end

`ifdef CLK_ADJ_BLINK_EN
    logic r_blink;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink <= 1'b1;
        end else if (w_state_nxt == RUN || (w_edit && (btn_up || btn_down))) begin
            r_blink <= 1'b1;
        end else if (w_adj && tick_1hz) begin
            r_blink <= ~r_blink;
        end
    end

    assign blink = r_blink;
`else
    assign blink = 1'b1;
`endif

    assign adj_mode   = w_adj;
    assign sel_field  = r_sel;
    assign alarm_ring = r_ring;

endmodule

`default_nettype wire

// File: tb/tb_clock_adjust_ctrl.sv
// ============================================================================
//  Module      : tb_clock_adjust_ctrl
//  Description : Directed, table-driven self-checking bench for
//                clock_adjust_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clock_adjust_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0;
    logic       alarm_en = 1'b0;
    logic [4:0] hours, alarm_hours;
    logic [5:0] minutes, seconds, alarm_minutes;
    logic       adj_mode, blink, alarm_ring;
    logic [1:0] sel_field;

    clock_adjust_ctrl dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_left(btn_left), .btn_right(btn_right),
        .btn_up(btn_up), .btn_down(btn_down), .alarm_en(alarm_en),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .adj_mode(adj_mode), .sel_field(sel_field), .blink(blink),
        .alarm_ring(alarm_ring)
    );

    always #5 clk = ~clk;

    // Button code: {mode, left, right, up, down, tick}.
    typedef struct packed {
        logic [5:0]  btn;
        logic [31:0] exp;
    } vec_t;

    vec_t        vq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] snap;

    assign snap = {hours, minutes, seconds, alarm_hours, alarm_minutes, adj_mode, sel_field, blink};

    function automatic logic [31:0] e(int hr, int mi, int se, int ahr, int ami, int adj, int sel);
        return {5'(hr), 6'(mi), 6'(se), 5'(ahr), 6'(ami), 1'(adj), 2'(sel), 1'b1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [5:0] b);
        @(negedge clk);
        {btn_mode, btn_left, btn_right, btn_up, btn_down, tick_1hz} = b;
        @(posedge clk);
        #1;
        {btn_mode, btn_left, btn_right, btn_up, btn_down, tick_1hz} = 6'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(6'b000001);
    endtask

    initial begin
        vq.push_back('{6'b100000, e( 0, 1, 0, 7, 0, 1, 0)});
        vq.push_back('{6'b001000, e( 0, 1, 0, 7, 0, 1, 1)});
        vq.push_back('{6'b000010, e(23, 1, 0, 7, 0, 1, 1)});
        vq.push_back('{6'b000010, e(22, 1, 0, 7, 0, 1, 1)});
        vq.push_back('{6'b000010, e(21, 1, 0, 7, 0, 1, 1)});
        vq.push_back('{6'b010000, e(21, 1, 0, 7, 0, 1, 0)});
        vq.push_back('{6'b010000, e(21, 1, 0, 7, 0, 1, 3)});
        vq.push_back('{6'b000100, e(21, 1, 0, 8, 0, 1, 3)});
        vq.push_back('{6'b000010, e(21, 1, 0, 7, 0, 1, 3)});
        vq.push_back('{6'b010000, e(21, 1, 0, 7, 0, 1, 2)});
        vq.push_back('{6'b000010, e(21, 1, 0, 7,59, 1, 2)});
        vq.push_back('{6'b000100, e(21, 1, 0, 7, 0, 1, 2)});
        vq.push_back('{6'b001000, e(21, 1, 0, 7, 0, 1, 3)});
        vq.push_back('{6'b011000, e(21, 1, 0, 7, 0, 1, 3)});
        vq.push_back('{6'b001000, e(21, 1, 0, 7, 0, 1, 0)});
        vq.push_back('{6'b000010, e(21, 0, 0, 7, 0, 1, 0)});
        vq.push_back('{6'b000010, e(21,59, 0, 7, 0, 1, 0)});
        vq.push_back('{6'b000100, e(21, 0, 0, 7, 0, 1, 0)});
        vq.push_back('{6'b000110, e(21, 0, 0, 7, 0, 1, 0)});
        vq.push_back('{6'b000010, e(21,59, 0, 7, 0, 1, 0)});
        vq.push_back('{6'b001100, e(21, 0, 0, 7, 0, 1, 1)});
        vq.push_back('{6'b000001, e(21, 0, 0, 7, 0, 1, 1)});
        vq.push_back('{6'b000100, e(22, 0, 0, 7, 0, 1, 1)});
        vq.push_back('{6'b000100, e(23, 0, 0, 7, 0, 1, 1)});
        vq.push_back('{6'b100100, e(23, 0, 0, 7, 0, 0, 1)});
        vq.push_back('{6'b100000, e(23, 0, 0, 7, 0, 1, 1)});
        vq.push_back('{6'b010000, e(23, 0, 0, 7, 0, 1, 0)});
        vq.push_back('{6'b000010, e(23,59, 0, 7, 0, 1, 0)});
        vq.push_back('{6'b100000, e(23,59, 0, 7, 0, 0, 0)});
        vq.push_back('{6'b100100, e(23,59, 0, 7, 0, 1, 0)});
        vq.push_back('{6'b100000, e(23,59, 0, 7, 0, 0, 0)});
        vq.push_back('{6'b000100, e(23,59, 0, 7, 0, 0, 0)});
        vq.push_back('{6'b011010, e(23,59, 0, 7, 0, 0, 0)});

        #1 rst = 1'b1;
        #2;
        check("reset_async", snap, e(0, 0, 0, 7, 0, 0, 0));
        check("reset_ring", 32'(alarm_ring), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        ticks(60);
        check("run_60_ticks", snap, e(0, 1, 0, 7, 0, 0, 0));

        for (int i = 0; i < vq.size(); i++) begin
            pulse(vq[i].btn);
            check($sformatf("vec%0d", i), snap, vq[i].exp);
        end

        ticks(58);
        check("run_235958", snap, e(23, 59, 58, 7, 0, 0, 0));
        ticks(1);
        check("run_235959", snap, e(23, 59, 59, 7, 0, 0, 0));
        ticks(1);
        check("full_carry_wrap", snap, e(0, 0, 0, 7, 0, 0, 0));

        ticks(37);
        pulse(6'b100000);
        pulse(6'b000001);
        check("adj_sec_frozen", snap, e(0, 0, 37, 7, 0, 1, 0));
        pulse(6'b100000);
        check("exit_sec_clear", snap, e(0, 0, 0, 7, 0, 0, 0));

        // Clock to 06:59:59, alarm 07:00 armed.
        pulse(6'b100000);
        pulse(6'b000010);
        pulse(6'b001000);
        for (int i = 0; i < 6; i++) pulse(6'b000100);
        pulse(6'b100000);
        check("set_0659", snap, e(6, 59, 0, 7, 0, 0, 1));
        ticks(59);
        alarm_en = 1'b1;
        ticks(1);
        check("ring_time", snap, e(7, 0, 0, 7, 0, 0, 1));
        check("ring_set", 32'(alarm_ring), 32'd1);
        pulse(6'b000000);
        check("ring_hold", 32'(alarm_ring), 32'd1);
        pulse(6'b000100);
        check("ring_dismiss", 32'(alarm_ring), 32'd0);
        check("dismiss_time", snap, e(7, 0, 0, 7, 0, 0, 1));

        // Same crossing with the alarm disarmed.
        alarm_en = 1'b0;
        pulse(6'b100000);
        pulse(6'b000010);
        pulse(6'b010000);
        pulse(6'b000010);
        pulse(6'b100000);
        check("reset_0659", snap, e(6, 59, 0, 7, 0, 0, 0));
        ticks(60);
        check("noring_time", snap, e(7, 0, 0, 7, 0, 0, 0));
        check("noring_en0", 32'(alarm_ring), 32'd0);

        // Alarm to 07:01, ring, clear via alarm_en, then reset mid-ADJUST.
        pulse(6'b100000);
        pulse(6'b001000);
        pulse(6'b001000);
        pulse(6'b000100);
        pulse(6'b100000);
        check("alarm_0701", snap, e(7, 0, 0, 7, 1, 0, 2));
        alarm_en = 1'b1;
        ticks(59);
        check("no_early_ring", 32'(alarm_ring), 32'd0);
        ticks(1);
        check("ring2_time", snap, e(7, 1, 0, 7, 1, 0, 2));
        check("ring2_set", 32'(alarm_ring), 32'd1);
        alarm_en = 1'b0;
        pulse(6'b000000);
        check("ring_en_clear", 32'(alarm_ring), 32'd0);
        pulse(6'b100000);
        pulse(6'b000100);
        check("pre_rst_adj", snap, e(7, 1, 0, 7, 2, 1, 2));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_async", snap, e(0, 0, 0, 7, 0, 0, 0));
        check("mid_rst_ring", 32'(alarm_ring), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulse(6'b000000);
        check("post_rst_idle", snap, e(0, 0, 0, 7, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
